div_seq_ctrl: RTL and testbench



---
 rtl/div_pkg.sv | 31 +++
 rtl/div_seq_ctrl_watchdog.sv | 39 +++
 rtl/div_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider FIFO sequencer.
// Holds the FSM state encoding, word-layout constants and small state helpers.
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_PUSH_Q = 3'd5,
    S_PUSH_R = 3'd6
  } state_e;

  localparam int PAYLOAD_W = 64;
  localparam int TAG_BIT   = 64;

  localparam logic TAG_QUOT = 1'b0;
  localparam logic TAG_REM  = 1'b1;

  localparam logic [PAYLOAD_W-1:0] DZ_QUOT = '1;

  function automatic logic is_load(input state_e s);
    return (s == S_LOAD_A) || (s == S_LOAD_B);
  endfunction

  function automatic logic is_push(input state_e s);
    return (s == S_PUSH_Q) || (s == S_PUSH_R);
  endfunction

endpackage

// File: rtl/div_seq_ctrl_watchdog.sv
// WAIT-state cycle counter for the divider sequencer.
// Ports: clk, rst (sync, high), clr_i, en_i; expire_o when count hits TIMEOUT-1.
module div_seq_ctrl_watchdog #(
  parameter int TIMEOUT = 80,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only meaningful while counting; the FSM looks at it in WAIT only.
  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer between byte-FIFO wrapper and divider: pops dividend and divisor
// words, launches one divide, pushes quotient then remainder words.
// Inputs : clk, rst (sync, high), in_valid/in_data (operand FIFO),
//          div_done/div_quot/div_rem (divider result), out_full (output FIFO).
// Outputs: in_ready (pop), div_start/div_signed/div_dividend/div_divisor,
//          out_valid/out_data (push), busy, dz_err, to_err (sticky per op).
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 65,
  parameter int TIMEOUT    = 80,
  parameter int CNT_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  div_start,
  output logic                  div_signed,
  output logic [63:0]           div_dividend,
  output logic [63:0]           div_divisor,
  input  logic                  div_done,
  input  logic [63:0]           div_quot,
  input  logic [63:0]           div_rem,
  input  logic                  out_full,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  dz_err,
  output logic                  to_err
);

  state_e state_q, state_d;

  logic [PAYLOAD_W-1:0] dvd_q, dvd_d;
  logic [PAYLOAD_W-1:0] dvs_q, dvs_d;
  logic [PAYLOAD_W-1:0] quot_q, quot_d;
  logic [PAYLOAD_W-1:0] rem_q, rem_d;
  logic                 sgn_q, sgn_d;
  logic                 dz_q, dz_d;
  logic                 to_q, to_d;

  logic wd_clr;
  logic wd_en;
  logic wd_expire;

  logic [PAYLOAD_W-1:0] in_pay;
  assign in_pay = in_data[PAYLOAD_W-1:0];

  assign wd_clr = (state_q == S_START);
  assign wd_en  = (state_q == S_WAIT);

  div_seq_ctrl_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    dz_d    = dz_q;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        if (in_valid) begin
          dvd_d   = in_pay;
          sgn_d   = in_data[TAG_BIT];
          dz_d    = 1'b0;
          to_d    = 1'b0;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (in_valid) begin
          dvs_d = in_pay;
          // Zero divisor never reaches the divider.
          if (in_pay == '0) begin
            quot_d  = DZ_QUOT;
            rem_d   = dvd_q;
            dz_d    = 1'b1;
            state_d = S_PUSH_Q;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result on the expiry cycle is still taken.
        if (div_done) begin
          quot_d  = div_quot;
          rem_d   = div_rem;
          state_d = S_PUSH_Q;
        end else if (wd_expire) begin
          quot_d  = '0;
          rem_d   = '0;
          to_d    = 1'b1;
          state_d = S_PUSH_Q;
        end
      end
      S_PUSH_Q: begin
        if (!out_full) begin
          state_d = S_PUSH_R;
        end
      end
      S_PUSH_R: begin
        if (!out_full) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      dz_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      dz_q    <= dz_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    unique case (1'b1)
      is_load(state_q): begin
        in_ready = in_valid;
      end
      (state_q == S_PUSH_Q): begin
        out_valid = !out_full;
        out_data  = {TAG_QUOT, quot_q};
      end
      (state_q == S_PUSH_R): begin
        out_valid = !out_full;
        out_data  = {TAG_REM, rem_q};
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign div_start    = (state_q == S_START);
  assign div_signed   = sgn_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign busy         = (state_q != S_IDLE);
  assign dz_err       = dz_q;
  assign to_err       = to_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: vector table plus
// backpressure, timeout/late-done and reset-mid-WAIT sequences.
module tb_div_seq_ctrl;

  localparam int TIMEOUT = 80;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [64:0] in_data;
  logic        in_ready;
  logic        div_start;
  logic        div_signed;
  logic [63:0] div_dividend;
  logic [63:0] div_divisor;
  logic        div_done = 1'b0;
  logic [63:0] div_quot = '0;
  logic [63:0] div_rem = '0;
  logic        out_full;
  logic        out_valid;
  logic [64:0] out_data;
  logic        busy;
  logic        dz_err;
  logic        to_err;

  always #5 clk = ~clk;

  div_seq_ctrl #(
    .DATA_WIDTH (65),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (7)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_done     (div_done),
    .div_quot     (div_quot),
    .div_rem      (div_rem),
    .out_full     (out_full),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .busy         (busy),
    .dz_err       (dz_err),
    .to_err       (to_err)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int starts = 0;
  int pop_cyc = 0;
  logic [64:0] pq[$];
  int push_cyc[$];

  int          m_lat = 0;
  int          m_cd = 0;
  logic [63:0] m_q = '0;
  logic [63:0] m_r = '0;
  logic        m_force = 1'b0;

  // Monitor and divider model, sampled mid-low-phase.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (in_ready) pop_cyc = cyc;
    if (out_valid) begin
      pq.push_back(out_data);
      push_cyc.push_back(cyc);
    end
    div_done = 1'b0;
    if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) begin
        div_done = 1'b1;
        div_quot = m_q;
        div_rem  = m_r;
      end
    end
    if (m_force) begin
      div_done = 1'b1;
      div_quot = m_q;
      div_rem  = m_r;
    end
    if (div_start) begin
      starts++;
      if (m_lat > 0) m_cd = m_lat;
    end
    if (rst) m_cd = 0;
  end

  task automatic chk(input string nm, input logic [64:0] act,
                     input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic feed(input logic [64:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    #1;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) bound_fail("feed_pop");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_pushes(input int target, input int budget);
    int n;
    n = 0;
    while (pq.size() < target && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (pq.size() < target) bound_fail("push_wait");
    @(negedge clk);
  endtask

  function automatic logic [64:0] pq_at(input int i);
    if (i < pq.size()) return pq[i];
    return 'x;
  endfunction

  typedef struct {
    logic [64:0] a;
    logic [64:0] b;
    int          lat;
    logic [63:0] mq;
    logic [63:0] mr;
    logic [64:0] eq;
    logic [64:0] er;
    int          est;
    logic        esg;
    logic        edz;
    logic        eto;
    int          elat;
  } vec_t;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t vecs[7];

  initial begin
    int p0;
    int s0;
    int n;

    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    int s0;
    int n;

    vecs[0] = '{{1'b0, 64'd100}, {1'b0, 64'd7}, 10, 64'd14, 64'd2,
                {1'b0, 64'd14}, {1'b1, 64'd2}, 1, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{{1'b1, 64'hFFFF_FFFF_FFFF_FFF9}, {1'b1, 64'd2}, 4,
                64'hFFFF_FFFF_FFFF_FFFD, ONES,
                {1'b0, 64'hFFFF_FFFF_FFFF_FFFD}, {1'b1, ONES},
                1, 1'b1, 1'b0, 1'b0, 0};
    vecs[2] = '{{1'b0, 64'd55}, {1'b0, 64'd0}, 5, 64'd0, 64'd0,
                {1'b0, ONES}, {1'b1, 64'd55}, 0, 1'b0, 1'b1, 1'b0, 1};
    vecs[3] = '{{1'b1, 64'hFFFF_FFFF_FFFF_FFFB}, {1'b1, 64'd0}, 5,
                64'd0, 64'd0, {1'b0, ONES},
                {1'b1, 64'hFFFF_FFFF_FFFF_FFFB}, 0, 1'b1, 1'b1, 1'b0, 1};
    vecs[4] = '{{1'b0, 64'd1000}, {1'b0, 64'd3}, 0, 64'd0, 64'd0,
                {1'b0, 64'd0}, {1'b1, 64'd0}, 1, 1'b0, 1'b0, 1'b1,
                TIMEOUT + 2};
    vecs[5] = '{{1'b0, 64'd9}, {1'b0, 64'd3}, 1, 64'd3, 64'd0,
                {1'b0, 64'd3}, {1'b1, 64'd0}, 1, 1'b0, 1'b0, 1'b0, 0};
    vecs[6] = '{{1'b0, ONES}, {1'b0, 64'd1}, 3, ONES, 64'd0,
                {1'b0, ONES}, {1'b1, 64'd0}, 1, 1'b0, 1'b0, 1'b0, 0};

    // Reset state, with in_valid high to show no pop while in reset.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = {1'b1, 64'h1234};
    out_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", {64'd0, busy}, 65'd0);
    chk("rst_in_ready", {64'd0, in_ready}, 65'd0);
    chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
    chk("rst_out_data", out_data, 65'd0);
    chk("rst_div_start", {64'd0, div_start}, 65'd0);
    chk("rst_flags", {63'd0, dz_err, to_err}, 65'd0);
    chk("rst_dividend", {1'b0, div_dividend}, 65'd0);
    chk("rst_divisor", {1'b0, div_divisor}, 65'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    #1;
    chk("busy_after_idle", {64'd0, busy}, 65'd1);
    @(negedge clk);

    // Table-driven operations.
    for (int i = 0; i < 7; i++) begin
      m_lat = vecs[i].lat;
      m_q   = vecs[i].mq;
      m_r   = vecs[i].mr;
      p0    = pq.size();
      s0    = starts;
      feed(vecs[i].a);
      feed(vecs[i].b);
      wait_pushes(p0 + 2, 300);
      chk($sformatf("v%0d_starts", i), 65'(starts - s0), 65'(vecs[i].est));
      chk($sformatf("v%0d_signed", i), {64'd0, div_signed},
          {64'd0, vecs[i].esg});
      chk($sformatf("v%0d_quot_word", i), pq_at(p0), vecs[i].eq);
      chk($sformatf("v%0d_rem_word", i), pq_at(p0 + 1), vecs[i].er);
      chk($sformatf("v%0d_pushes", i), 65'(pq.size() - p0), 65'd2);
      chk($sformatf("v%0d_dz_err", i), {64'd0, dz_err},
          {64'd0, vecs[i].edz});
      chk($sformatf("v%0d_to_err", i), {64'd0, to_err},
          {64'd0, vecs[i].eto});
      chk($sformatf("v%0d_dividend", i), {1'b0, div_dividend},
          {1'b0, vecs[i].a[63:0]});
      chk($sformatf("v%0d_divisor", i), {1'b0, div_divisor},
          {1'b0, vecs[i].b[63:0]});
      if (vecs[i].elat != 0 && push_cyc.size() > p0) begin
        chk($sformatf("v%0d_latency", i), 65'(push_cyc[p0] - pop_cyc),
            65'(vecs[i].elat));
      end
    end

    // Output backpressure: 5 stalled cycles in PUSH_Q, 3 in PUSH_R.
    out_full = 1'b1;
    m_lat    = 2;
    m_q      = 64'd5;
    m_r      = 64'd1;
    p0       = pq.size();
    feed({1'b0, 64'd11});
    feed({1'b0, 64'd2});
    n = 0;
    #1;
    while (out_data !== 65'h5 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (out_data !== 65'h5) bound_fail("bp_reach_push_q");
    for (int i = 0; i < 5; i++) begin
      chk("bp_q_valid", {64'd0, out_valid}, 65'd0);
      chk("bp_q_data", out_data, {1'b0, 64'd5});
      @(negedge clk);
      #1;
    end
    out_full = 1'b0;
    #1;
    chk("bp_q_release", {64'd0, out_valid}, 65'd1);
    @(negedge clk);
    out_full = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_r_valid", {64'd0, out_valid}, 65'd0);
      chk("bp_r_data", out_data, {1'b1, 64'd1});
      @(negedge clk);
      #1;
    end
    out_full = 1'b0;
    wait_pushes(p0 + 2, 20);
    chk("bp_quot_word", pq_at(p0), {1'b0, 64'd5});
    chk("bp_rem_word", pq_at(p0 + 1), {1'b1, 64'd1});
    repeat (5) @(negedge clk);
    chk("bp_push_count", 65'(pq.size() - p0), 65'd2);

    // Timeout held in PUSH_Q, then a late div_done that must be ignored.
    out_full = 1'b1;
    m_lat    = 0;
    p0       = pq.size();
    feed({1'b0, 64'd77});
    feed({1'b0, 64'd7});
    n = 0;
    #1;
    while (!to_err && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!to_err) bound_fail("to_reach_timeout");
    m_q     = 64'd123;
    m_r     = 64'd45;
    m_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_force = 1'b0;
    #1;
    chk("late_done_busy", {64'd0, busy}, 65'd1);
    chk("late_done_data", out_data, 65'd0);
    out_full = 1'b0;
    wait_pushes(p0 + 2, 20);
    chk("to_quot_word", pq_at(p0), {1'b0, 64'd0});
    chk("to_rem_word", pq_at(p0 + 1), {1'b1, 64'd0});
    chk("to_flag", {64'd0, to_err}, 65'd1);

    // Reset at WAIT cycle 4, then a clean 9/3.
    m_lat = 0;
    s0    = starts;
    p0    = pq.size();
    feed({1'b0, 64'd500});
    feed({1'b0, 64'd5});
    n = 0;
    #3;
    while (starts == s0 && n < 20) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (starts == s0) bound_fail("rw_start");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_busy", {64'd0, busy}, 65'd0);
    chk("rw_outputs", {62'd0, out_valid, div_start, in_ready}, 65'd0);
    chk("rw_out_data", out_data, 65'd0);
    chk("rw_regs", {div_dividend | div_divisor, div_signed}, 65'd0);
    chk("rw_flags", {63'd0, dz_err, to_err}, 65'd0);
    chk("rw_no_push", 65'(pq.size() - p0), 65'd0);
    m_lat = 3;
    m_q   = 64'd3;
    m_r   = 64'd0;
    feed({1'b0, 64'd9});
    feed({1'b0, 64'd3});
    wait_pushes(p0 + 2, 100);
    chk("rw_quot_word", pq_at(p0), {1'b0, 64'd3});
    chk("rw_rem_word", pq_at(p0 + 1), {1'b1, 64'd0});
    chk("rw_starts", 65'(starts - s0), 65'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
